// File: rtl/spi_arb_pkg.sv
// Shared types and the round-robin search helper for the SPI arbiter.
package spi_arb_pkg;

   localparam int unsigned MAX_REQ = 8;

   typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} arb_state_t;

   typedef struct packed {
      logic        found;
      int unsigned idx;
   } pick_t;

   // Scanning ptr, ptr+1, ... with wrap is the same as rotate, priority-encode, un-rotate.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input int unsigned        ptr,
                                     input int unsigned        n);
      pick_t       p;
      int unsigned j;
      p.found = 1'b0;
      p.idx   = 0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         j = ptr + k;
         if (j >= n) j = j - n;
         if (k < n && !p.found && req[j[2:0]]) begin
            p.found = 1'b1;
            p.idx   = j;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module spi_rr_picker
   import spi_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDXW-1:0]    ptr_i,
   output logic [IDXW-1:0]    idx_o,
   output logic               found_o
);

   pick_t pick;

   always_comb begin
      pick = rr_pick(MAX_REQ'(req_i), 32'(ptr_i), NUM_REQ);
   end

   assign idx_o   = IDXW'(pick.idx);
   assign found_o = pick.found;

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI driver between NUM_REQ requesters.
// Define SPI_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned CS_GAP      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*8-1:0]   req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [7:0]             rsp_data,
   output logic                   rsp_err,
   output logic                   drv_start,
   output logic [7:0]             drv_data,
   input  logic                   drv_done,
   input  logic [7:0]             drv_rdata,
   output logic [NUM_REQ-1:0]     cs_sel,
   output logic                   busy
);

   localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned WDW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   arb_state_t          state_q, state_d;
   logic [IDXW-1:0]     rr_q, rr_d, idx_q, idx_d;
   logic [WDW-1:0]      wd_q, wd_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d, rspv_q, rspv_d, cs_q, cs_d;
   logic [7:0]          rsp_data_q, rsp_data_d, drv_data_q, drv_data_d;
   logic                rsp_err_q, rsp_err_d, start_q, start_d, busy_q, busy_d;

   logic [NUM_REQ-1:0]  pick_req;
   logic [IDXW-1:0]     pick_idx, win;
   logic                pick_found, win_found, rr_adv;

`ifdef SPI_ARB_PRIO_EN
   // Requester 0 bypasses the rotation; the pointer only tracks requesters 1..N-1.
   assign pick_req  = req & ~NUM_REQ'(1);
   assign win_found = req[0] | pick_found;
   assign win       = req[0] ? '0 : pick_idx;
   assign rr_adv    = (idx_q != '0);
`else
   assign pick_req  = req;
   assign win_found = pick_found;
   assign win       = pick_idx;
   assign rr_adv    = 1'b1;
`endif

   spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (pick_req),
      .ptr_i   (rr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      idx_d      = idx_q;
      wd_d       = wd_q;
      gap_d      = gap_q;
      ack_d      = '0;
      rspv_d     = '0;
      start_d    = 1'b0;
      cs_d       = cs_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      drv_data_d = drv_data_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               idx_d      = win;
               ack_d      = NUM_REQ'(1) << win;
               cs_d       = NUM_REQ'(1) << win;
               start_d    = 1'b1;
               drv_data_d = req_data[32'(win)*8 +: 8];
               wd_d       = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (drv_done) begin
               rsp_data_d = drv_rdata;
               rsp_err_d  = 1'b0;
               rspv_d     = NUM_REQ'(1) << idx_q;
               cs_d       = '0;
               state_d    = RESP;
            end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               rspv_d     = NUM_REQ'(1) << idx_q;
               cs_d       = '0;
               state_d    = RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESP: begin
            if (rr_adv) rr_d = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            gap_d   = '0;
            state_d = GAP;
         end
         GAP: begin
            if (gap_q == GW'(CS_GAP - 1)) state_d = IDLE;
            else                          gap_d   = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         idx_q      <= '0;
         wd_q       <= '0;
         gap_q      <= '0;
         ack_q      <= '0;
         rspv_q     <= '0;
         cs_q       <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         drv_data_q <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         idx_q      <= idx_d;
         wd_q       <= wd_d;
         gap_q      <= gap_d;
         ack_q      <= ack_d;
         rspv_q     <= rspv_d;
         cs_q       <= cs_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         drv_data_q <= drv_data_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign rsp_valid = rspv_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign drv_start = start_q;
   assign drv_data  = drv_data_q;
   assign cs_sel    = cs_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter (NUM_REQ=4, TIMEOUT_CYC=16, CS_GAP=2) with a behavioural SPI driver.
module tb_spi_arbiter;

   localparam int NREQ = 4;
   localparam int GAPC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack, rsp_valid, cs_sel;
   logic [7:0]  rsp_data, drv_data, drv_rdata;
   logic        rsp_err, drv_start, drv_done, busy;

   always #5 clk = ~clk;

   spi_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(16), .CS_GAP(GAPC)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .drv_start(drv_start), .drv_data(drv_data), .drv_done(drv_done),
      .drv_rdata(drv_rdata), .cs_sel(cs_sel), .busy(busy)
   );

   typedef struct {logic [3:0] oh; logic [7:0] data;} gexp_t;
   typedef struct {logic [3:0] oh; logic [7:0] data; logic err; int lat;} rexp_t;
   typedef struct {int delay; logic [7:0] data;} drv_t;

   gexp_t gq[$];
   rexp_t rq[$];
   drv_t  dq[$];

   int checks = 0, errors = 0;
   int cyc = 0, last_start_cyc = 0, last_rsp_cyc = 0, rsp_seen = 0, exp_rsp = 0;
   bit chk_gap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SPI driver model: delay d means drv_done is sampled while the watchdog reads d.
   initial begin
      drv_t e;
      drv_done  = 1'b0;
      drv_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (drv_start && !rst) begin
            if (dq.size() != 0) e = dq.pop_front();
            else                e = '{-1, 8'h00};
            if (e.delay >= 0) begin
               repeat (e.delay) @(posedge clk);
               #1;
               drv_done  = 1'b1;
               drv_rdata = e.data;
               @(posedge clk); #1;
               drv_done  = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a grant or a response.
   initial begin
      gexp_t      g;
      rexp_t      r;
      bit         prev_ack = 0;
      logic [3:0] prev_cs  = '0;
      logic [7:0] prev_dd  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ack = 0;
         end else begin
            if (prev_ack) begin
               chk("ack_one_cycle", 32'(ack), 32'h0);
               chk("start_one_cycle", 32'(drv_start), 32'h0);
               chk("cs_held", 32'(cs_sel), 32'(prev_cs));
               chk("drv_data_held", 32'(drv_data), 32'(prev_dd));
            end
            prev_ack = 0;
            if (ack != '0) begin
               if (gq.size() == 0) chk("unexpected_ack", 32'(ack), 32'h0);
               else begin
                  g = gq.pop_front();
                  chk("ack", 32'(ack), 32'(g.oh));
                  chk("drv_start", 32'(drv_start), 32'h1);
                  chk("drv_data", 32'(drv_data), 32'(g.data));
                  chk("cs_sel", 32'(cs_sel), 32'(g.oh));
                  chk("busy", 32'(busy), 32'h1);
                  if (chk_gap) chk("idle_gap", 32'(cyc - last_rsp_cyc - 1), 32'(GAPC + 1));
               end
               prev_ack = 1;
               prev_cs  = cs_sel;
               prev_dd  = drv_data;
            end
            if (drv_start) last_start_cyc = cyc;
            if (rsp_valid != '0) begin
               rsp_seen++;
               if (rq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
               else begin
                  r = rq.pop_front();
                  chk("rsp_valid", 32'(rsp_valid), 32'(r.oh));
                  chk("rsp_data", 32'(rsp_data), 32'(r.data));
                  chk("rsp_err", 32'(rsp_err), 32'(r.err));
                  chk("rsp_cs_clear", 32'(cs_sel), 32'h0);
                  chk("rsp_latency", 32'(cyc - last_start_cyc), 32'(r.lat));
               end
               last_rsp_cyc = cyc;
            end
         end
      end
   end

   task automatic grant_wait(output int lat);
      bit seen;
      seen = 0;
      lat  = 0;
      for (int i = 1; i <= 100 && !seen; i++) begin
         @(posedge clk); #1;
         if (ack != '0) begin
            seen = 1;
            lat  = i;
         end
      end
      chk("grant_seen", 32'(seen), 32'h1);
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 200 && rsp_seen < n; i++) @(posedge clk);
      #1;
      chk("rsp_count", 32'(rsp_seen), 32'(n));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack"}, 32'(ack), 32'h0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
      chk({tag, "_drv_start"}, 32'(drv_start), 32'h0);
      chk({tag, "_drv_data"}, 32'(drv_data), 32'h0);
      chk({tag, "_cs_sel"}, 32'(cs_sel), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int lat;
      rst = 1'b1; req = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Single request on requester 1.
      req_data = 32'h0000_A500;
      dq.push_back('{10, 8'h3C});
      gq.push_back('{4'b0010, 8'hA5});
      rq.push_back('{4'b0010, 8'h3C, 1'b0, 11});
      req = 4'b0010;
      grant_wait(lat);
      chk("ack_latency", 32'(lat), 32'h1);
      req = '0;
      exp_rsp += 1; wait_rsp(exp_rsp);

      // Round-robin with all requests held.
      pulse_reset();
      req_data = 32'h4433_2211;
      for (int i = 0; i < 5; i++) begin
         gq.push_back('{4'b0001 << (i % 4), 8'h11 * 8'((i % 4) + 1)});
         dq.push_back('{3, 8'hE0 + 8'(i)});
         rq.push_back('{4'b0001 << (i % 4), 8'hE0 + 8'(i), 1'b0, 4});
      end
      req = 4'b1111;
      grant_wait(lat);
      @(negedge clk); #1;
      chk_gap = 1;
      for (int i = 0; i < 3; i++) grant_wait(lat);
      grant_wait(lat);
      req = '0;
      @(negedge clk); #1;
      chk_gap = 0;
      exp_rsp += 5; wait_rsp(exp_rsp);

      // Timeout, then a normal request.
      req_data = 32'h0000_005A;
      dq.push_back('{-1, 8'h00});
      gq.push_back('{4'b0001, 8'h5A});
      rq.push_back('{4'b0001, 8'h00, 1'b1, 16});
      req = 4'b0001;
      grant_wait(lat);
      req = '0;
      exp_rsp += 1; wait_rsp(exp_rsp);
      req_data = 32'hC300_0000;
      dq.push_back('{2, 8'h99});
      gq.push_back('{4'b1000, 8'hC3});
      rq.push_back('{4'b1000, 8'h99, 1'b0, 3});
      req = 4'b1000;
      grant_wait(lat);
      req = '0;
      exp_rsp += 1; wait_rsp(exp_rsp);

      // drv_done on the last watchdog cycle wins over the timeout.
      req_data = 32'h0010_0000;
      dq.push_back('{15, 8'h77});
      gq.push_back('{4'b0100, 8'h10});
      rq.push_back('{4'b0100, 8'h77, 1'b0, 16});
      req = 4'b0100;
      grant_wait(lat);
      req = '0;
      exp_rsp += 1; wait_rsp(exp_rsp);

      // drv_done one cycle late lands in RESP and is ignored.
      req_data = 32'h0000_2000;
      dq.push_back('{16, 8'h55});
      gq.push_back('{4'b0010, 8'h20});
      rq.push_back('{4'b0010, 8'h00, 1'b1, 16});
      req = 4'b0010;
      grant_wait(lat);
      req = '0;
      exp_rsp += 1; wait_rsp(exp_rsp);
      @(posedge clk); #1;
      chk("hold_rsp_data", 32'(rsp_data), 32'h00);
      chk("hold_rsp_err", 32'(rsp_err), 32'h1);
      chk("hold_drv_data", 32'(drv_data), 32'h20);
      chk("gap_busy", 32'(busy), 32'h1);
      repeat (4) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'h0);

      // Reset mid-RUN; pointer sits at 2, so a correct reset grants 0 before 3.
      req_data = 32'h005C_0000;
      dq.push_back('{-1, 8'h00});
      gq.push_back('{4'b0100, 8'h5C});
      req = 4'b0100;
      grant_wait(lat);
      req = '0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("midrun");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_busy", 32'(busy), 32'h0);
      req_data = 32'h0800_0001;
      dq.push_back('{1, 8'h6B});
      dq.push_back('{2, 8'h4D});
      gq.push_back('{4'b0001, 8'h01});
      gq.push_back('{4'b1000, 8'h08});
      rq.push_back('{4'b0001, 8'h6B, 1'b0, 2});
      rq.push_back('{4'b1000, 8'h4D, 1'b0, 3});
      req = 4'b1001;
      grant_wait(lat);
      req = 4'b1000;
      grant_wait(lat);
      req = '0;
      exp_rsp += 2; wait_rsp(exp_rsp);

`ifdef SPI_ARB_PRIO_EN
      // Requester 0 raised during RUN jumps ahead of pending 2 and 3.
      pulse_reset();
      req_data = 32'h0403_0201;
      gq.push_back('{4'b0010, 8'h02});
      gq.push_back('{4'b0001, 8'h01});
      gq.push_back('{4'b0100, 8'h03});
      gq.push_back('{4'b1000, 8'h04});
      rq.push_back('{4'b0010, 8'hA1, 1'b0, 3});
      rq.push_back('{4'b0001, 8'hA2, 1'b0, 3});
      rq.push_back('{4'b0100, 8'hA3, 1'b0, 3});
      rq.push_back('{4'b1000, 8'hA4, 1'b0, 3});
      for (int i = 0; i < 4; i++) dq.push_back('{2, 8'hA1 + 8'(i)});
      req = 4'b1110;
      grant_wait(lat);
      req = 4'b1100;
      @(posedge clk); #1;
      req = 4'b1101;
      grant_wait(lat);
      req = 4'b1100;
      grant_wait(lat);
      req = 4'b1000;
      grant_wait(lat);
      req = '0;
      exp_rsp += 4; wait_rsp(exp_rsp);
`endif

      repeat (5) @(posedge clk);
      #1;
      chk("grant_queue_empty", 32'(gq.size()), 32'h0);
      chk("rsp_queue_empty", 32'(rq.size()), 32'h0);
      chk("drv_queue_empty", 32'(dq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
